systolic_scheduler: RTL and testbench
=====================================

# systolic_scheduler

Parametrised control sequencer for the weight-stationary systolic array. Per tile it loads weights one row per cycle, then runs the multiply wavefront: rows enable staggered from the top, stay on for the full column sweep, and drain off in the same order. It sequences a run of several tiles from a start handshake, with optional weight reuse across tiles and a synchronous abort. It sits between the top-level controller and the PE array row-control inputs.

## Interface
- ROWS, 4, PE rows; width of the row-control vectors
- COLS, 4, PE columns; sets how long each row stays enabled
- STAGGER, 4, cycles between successive row enables/disables (≥1)
- TILE_W, 8, width of the tile count and tile index
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low
- general_enable  in  1  global advance; 0 freezes all state and outputs
- start  in  1  run request; accepted only in IDLE with general_enable=1
- num_tiles  in  TILE_W  tiles in the run, sampled at start; 0 is treated as 1
- reuse_weights  in  1  sampled at start; 1 means weights are loaded for tile 0 only
- abort  in  1  synchronous cancel, honoured in LOAD/COMPUTE when general_enable=1
- busy  out  1  high from the first LOAD/COMPUTE cycle through the last COMPUTE cycle
- load_weight  out  ROWS  one-hot; bit k high in load cycle k
- enable_mult  out  ROWS  per-row multiply enable, MSB = first row
- tile_idx  out  TILE_W  index of the tile in progress
- tile_done  out  1  high in the last COMPUTE cycle of each tile
- done  out  1  high in the last COMPUTE cycle of the final tile

## Operation
- FSM states: IDLE, LOAD, COMPUTE.
- IDLE → LOAD on accepted start. Latch num_tiles (0 → 1) and reuse_weights, and set tile_idx=0.
- LOAD lasts ROWS cycles, one row per cycle. Then go to COMPUTE.
- COMPUTE lasts L = (ROWS+COLS−1)·STAGGER cycles, counted by cnt = 0..L−1. Step s = cnt/STAGGER.
- Row i (bit ROWS−1−i) is enabled when i ≤ s < i+COLS. The result is a thermometer ramp-up, a hold, then a ramp-down.
- On the last COMPUTE cycle, assert tile_done.
  - If tile_idx = num_tiles−1: assert done and go to IDLE.
  - Otherwise: increment tile_idx and go to LOAD, or straight to COMPUTE if reuse_weights=1.
- Abort returns the block to IDLE on the next cycle with all outputs 0. No tile_done or done is produced.
  - Abort in IDLE is ignored.
  - Abort and start together in IDLE: abort wins.
- start while busy is ignored.

## Timing
- All outputs are registered.
- Reset value: busy, load_weight, enable_mult, tile_idx, tile_done and done are all 0.
- Reset clears outputs asynchronously. The state machine resumes from IDLE on the first rising edge after reset deasserts.
- Cycle 0 is the cycle in which start is sampled. LOAD occupies cycles 1..ROWS and COMPUTE occupies cycles ROWS+1..ROWS+L.
- A following tile starts on the cycle after tile_done, with no bubble.
- busy falls on the cycle after done.
- general_enable=0 holds every register, including the pulses. A pulse lasts exactly one enabled cycle, and downstream qualifies it with general_enable.
- Counter widths: cnt uses $clog2(L). tile_idx wraps only through run completion and never exceeds num_tiles−1.

## Structure
- Shared package systolic_pkg holds:
  - the enum sched_state_t {IDLE, LOAD, COMPUTE};
  - the function compute_len(ROWS, COLS, STAGGER).
- One sub-module, stagger_timer: divide-by-STAGGER step tick plus step counter, with enable and clear inputs.

## Test plan
All scenarios use ROWS=COLS=2, STAGGER=4.
- num_tiles=1, reuse=0, start at cycle 0 → load_weight 01 at cycle 1, 10 at cycle 2. enable_mult is 10 in cycles 3–6, 11 in cycles 7–10, 01 in cycles 11–14. tile_done and done high at cycle 14; busy low at cycle 15.
- num_tiles=3, reuse=1 → no LOAD after tile 0. tile_done at cycles 14, 26 and 38, with tile_idx 0, 1, 2. done only at cycle 38.
- num_tiles=2, reuse=0 → second LOAD in cycles 15–16 with load_weight 01/10. Second COMPUTE in cycles 17–28; done at cycle 28.
- general_enable low for cycles 8–10 → all outputs frozen at their cycle-7 values. done moves from cycle 14 to cycle 17.
- Abort at cycle 9 → cycle 10 has all outputs 0 and no done. Start at cycle 12 restarts tile 0 with load_weight 01 at cycle 13.
- Corner cases:
  - reset low mid-COMPUTE → outputs 0 immediately, and the block idles after release.
  - num_tiles=0 → a single tile, done at cycle 14.
  - start during busy → ignored.

Source files
------------

// File: rtl/systolic_scheduler_pkg.sv
// Shared types and helpers for the systolic array scheduler.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} sched_state_t;

    // Cycles needed for one full multiply wavefront across the array.
    function automatic int compute_len(int rows, int cols, int stagger);
        return (rows + cols - 1) * stagger;
    endfunction

endpackage

// File: rtl/systolic_scheduler_if.sv
// Controller <-> scheduler bundle: run request inputs and row-control outputs.
interface systolic_scheduler_if #(
    parameter int ROWS   = 4,
    parameter int TILE_W = 8
);
    logic              general_enable;
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              reuse_weights;
    logic              abort;
    logic              busy;
    logic [ROWS-1:0]   load_weight;
    logic [ROWS-1:0]   enable_mult;
    logic [TILE_W-1:0] tile_idx;
    logic              tile_done;
    logic              done;

    modport master (
        output general_enable, start, num_tiles, reuse_weights, abort,
        input  busy, load_weight, enable_mult, tile_idx, tile_done, done
    );

    modport slave (
        input  general_enable, start, num_tiles, reuse_weights, abort,
        output busy, load_weight, enable_mult, tile_idx, tile_done, done
    );
endinterface

// File: rtl/systolic_scheduler_stagger_timer.sv
// Divide-by-STAGGER tick plus wavefront step counter; exposes next values so
// the owner can register outputs that describe the upcoming cycle.
module stagger_timer #(
    parameter int STAGGER = 4,
    parameter int SW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic          adv,
    output logic          tick,
    output logic          tick_nxt,
    output logic [SW-1:0] step,
    output logic [SW-1:0] step_nxt
);
    localparam int DW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    logic [DW-1:0] div_q, div_nxt;

    assign tick     = (div_q   == DW'(STAGGER - 1));
    assign tick_nxt = (div_nxt == DW'(STAGGER - 1));

    always_comb begin
        div_nxt  = div_q;
        step_nxt = step;
        if (clr) begin
            div_nxt  = '0;
            step_nxt = '0;
        end else if (adv) begin
            if (tick) begin
                div_nxt  = '0;
                step_nxt = step + SW'(1);
            end else begin
                div_nxt  = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            step  <= '0;
        end else if (en) begin
            div_q <= div_nxt;
            step  <= step_nxt;
        end
    end
endmodule

// File: rtl/systolic_scheduler.sv
// Weight-stationary array sequencer: per tile, row-by-row weight load then a
// staggered multiply wavefront; runs several tiles with optional weight reuse.
module systolic_scheduler
    import systolic_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int STAGGER = 4,
    parameter int TILE_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_scheduler_if.slave  sb
);
    localparam int L     = compute_len(ROWS, COLS, STAGGER);
    localparam int STEPS = L / STAGGER;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    sched_state_t      state_q, state_nxt;
    logic [RW-1:0]     row_q, row_nxt;
    logic [TILE_W-1:0] tiles_q, tiles_nxt, tile_nxt;
    logic              reuse_q, reuse_nxt;
    logic              clr, adv, last;
    logic              tick, tick_nxt;
    logic [SW-1:0]     step, step_nxt;
    logic [ROWS-1:0]   lw_d, em_d;
    logic              td_d, done_d;

    stagger_timer #(.STAGGER(STAGGER), .SW(SW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (sb.general_enable),
        .clr      (clr),
        .adv      (adv),
        .tick     (tick),
        .tick_nxt (tick_nxt),
        .step     (step),
        .step_nxt (step_nxt)
    );

    assign last = (state_q == COMPUTE) && (step == SW'(STEPS - 1)) && tick;

    always_comb begin
        state_nxt = state_q;
        row_nxt   = row_q;
        tiles_nxt = tiles_q;
        reuse_nxt = reuse_q;
        tile_nxt  = sb.tile_idx;
        clr       = 1'b1;
        adv       = 1'b0;
        case (state_q)
            IDLE: begin
                // abort suppresses a coincident start
                if (sb.start && !sb.abort) begin
                    state_nxt = LOAD;
                    row_nxt   = '0;
                    tile_nxt  = '0;
                    tiles_nxt = (sb.num_tiles == '0) ? TILE_W'(1) : sb.num_tiles;
                    reuse_nxt = sb.reuse_weights;
                end
            end
            LOAD: begin
                if (sb.abort) begin
                    state_nxt = IDLE;
                    tile_nxt  = '0;
                end else if (row_q == RW'(ROWS - 1)) begin
                    state_nxt = COMPUTE;
                end else begin
                    row_nxt   = row_q + RW'(1);
                end
            end
            COMPUTE: begin
                if (sb.abort) begin
                    state_nxt = IDLE;
                    tile_nxt  = '0;
                end else if (last) begin
                    if (sb.tile_idx == tiles_q - TILE_W'(1)) begin
                        state_nxt = IDLE;
                        tile_nxt  = '0;
                    end else begin
                        tile_nxt  = sb.tile_idx + TILE_W'(1);
                        state_nxt = reuse_q ? COMPUTE : LOAD;
                        row_nxt   = '0;
                    end
                end else begin
                    clr = 1'b0;
                    adv = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next-cycle view so they can be registered.
    always_comb begin
        em_d = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (state_nxt == COMPUTE && int'(step_nxt) >= i && int'(step_nxt) < i + COLS)
                em_d[ROWS-1-i] = 1'b1;
        end
        lw_d   = (state_nxt == LOAD) ? (ROWS'(1) << row_nxt) : '0;
        td_d   = (state_nxt == COMPUTE) && (step_nxt == SW'(STEPS - 1)) && tick_nxt;
        done_d = td_d && (tile_nxt == tiles_nxt - TILE_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            row_q          <= '0;
            tiles_q        <= TILE_W'(1);
            reuse_q        <= 1'b0;
            sb.busy        <= 1'b0;
            sb.load_weight <= '0;
            sb.enable_mult <= '0;
            sb.tile_idx    <= '0;
            sb.tile_done   <= 1'b0;
            sb.done        <= 1'b0;
        end else if (sb.general_enable) begin
            state_q        <= state_nxt;
            row_q          <= row_nxt;
            tiles_q        <= tiles_nxt;
            reuse_q        <= reuse_nxt;
            sb.busy        <= (state_nxt != IDLE);
            sb.load_weight <= lw_d;
            sb.enable_mult <= em_d;
            sb.tile_idx    <= tile_nxt;
            sb.tile_done   <= td_d;
            sb.done        <= done_d;
        end
    end
endmodule

// File: tb/tb_systolic_scheduler.sv
// Scoreboard bench for systolic_scheduler at ROWS=COLS=2, STAGGER=4.
module tb_systolic_scheduler;
    localparam int ROWS = 2, COLS = 2, STAGGER = 4, TILE_W = 8;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0, total = 0, bad = 0;
    int   t0, nb;

    systolic_scheduler_if #(.ROWS(ROWS), .TILE_W(TILE_W)) sb();

    systolic_scheduler #(.ROWS(ROWS), .COLS(COLS), .STAGGER(STAGGER), .TILE_W(TILE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [13:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;

    function automatic logic [13:0] pack(input logic [1:0] lw, input logic [1:0] em,
                                         input logic [7:0] t, input logic td, input logic dn);
        return {lw, em, t, td, dn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int c, input logic [1:0] lw, input logic [1:0] em,
                       input logic [7:0] t, input logic td, input logic dn,
                       input int fz_from, input int fz_by, input int lim);
        exp_t x;
        if (c > lim) return;
        x.cyc = (c >= fz_from) ? c + fz_by : c;
        x.v   = pack(lw, em, t, td, dn);
        q.push_back(x);
    endtask

    // Hand-derived tile shape: two load cycles (01, 10) then 4x10, 4x11, 4x01.
    task automatic push_tile(input int base, input logic [7:0] tile, input bit ld, input bit fin,
                             input int fz_from, input int fz_by, input int lim, output int nbase);
        logic [1:0] lw_tab [2];
        logic [1:0] em_tab [3];
        int c;
        lw_tab = '{2'b01, 2'b10};
        em_tab = '{2'b10, 2'b11, 2'b01};
        c = base;
        if (ld) begin
            for (int r = 0; r < 2; r++) begin
                c++;
                add(c, lw_tab[r], 2'b00, tile, 1'b0, 1'b0, fz_from, fz_by, lim);
            end
        end
        for (int j = 0; j < 12; j++) begin
            c++;
            add(c, 2'b00, em_tab[j/4], tile, j == 11, (j == 11) && fin, fz_from, fz_by, lim);
        end
        nbase = c;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] nt, input logic r);
        sb.start = 1'b1;
        sb.num_tiles = nt;
        sb.reuse_weights = r;
        step(1);
        sb.start = 1'b0;
    endtask

    // Monitor: every enabled busy cycle consumes one expected record.
    logic [13:0] cur, snap;
    logic        snap_busy = 1'b0;
    logic        prev_ge = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            cur = pack(sb.load_weight, sb.enable_mult, sb.tile_idx, sb.tile_done, sb.done);
            if (!prev_ge)
                chk("hold_while_disabled", {17'd0, sb.busy, cur}, {17'd0, snap_busy, snap});
            if (sb.general_enable) begin
                if (sb.busy) begin
                    if (q.size() == 0) begin
                        chk("busy_without_expectation", {31'd0, sb.busy}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_outputs", {18'd0, cur}, {18'd0, e.v});
                    end
                end else begin
                    chk("idle_outputs", {26'd0, cur[13:10], cur[1:0]}, 32'd0);
                end
            end
            prev_ge   = sb.general_enable;
            snap      = cur;
            snap_busy = sb.busy;
        end
    end

    initial begin
        sb.general_enable = 1'b1;
        sb.start = 1'b0;
        sb.num_tiles = '0;
        sb.reuse_weights = 1'b0;
        sb.abort = 1'b0;
        step(2);
        chk("reset_outputs", {17'd0, sb.busy,
            pack(sb.load_weight, sb.enable_mult, sb.tile_idx, sb.tile_done, sb.done)}, 32'd0);
        reset = 1'b1;
        step(2);

        // single tile, with a start pulse while busy that must be ignored
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b1, BIG, 0, BIG, nb);
        go(8'd1, 1'b0);
        step(4);
        sb.start = 1'b1;
        sb.num_tiles = 8'd3;
        step(1);
        sb.start = 1'b0;
        step(14);
        chk("s1_drained", q.size(), 32'd0);

        // three tiles with weight reuse
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b0, BIG, 0, BIG, nb);
        push_tile(nb, 8'd1, 1'b0, 1'b0, BIG, 0, BIG, nb);
        push_tile(nb, 8'd2, 1'b0, 1'b1, BIG, 0, BIG, nb);
        go(8'd3, 1'b1);
        step(42);
        chk("s2_drained", q.size(), 32'd0);

        // two tiles, reload weights for the second
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b0, BIG, 0, BIG, nb);
        push_tile(nb, 8'd1, 1'b1, 1'b1, BIG, 0, BIG, nb);
        go(8'd2, 1'b0);
        step(32);
        chk("s3_drained", q.size(), 32'd0);

        // general_enable low for cycles 8..10 delays everything by three
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b1, t0 + 8, 3, BIG, nb);
        go(8'd1, 1'b0);
        step(7);
        sb.general_enable = 1'b0;
        step(3);
        sb.general_enable = 1'b1;
        step(10);
        chk("s4_drained", q.size(), 32'd0);

        // abort at cycle 9, restart at cycle 12
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b1, BIG, 0, t0 + 9, nb);
        go(8'd1, 1'b0);
        step(8);
        sb.abort = 1'b1;
        step(1);
        sb.abort = 1'b0;
        step(2);
        push_tile(cyc, 8'd0, 1'b1, 1'b1, BIG, 0, BIG, nb);
        go(8'd1, 1'b0);
        step(18);
        chk("s5_drained", q.size(), 32'd0);

        // abort in idle, and abort together with start: nothing happens
        sb.abort = 1'b1;
        step(2);
        sb.start = 1'b1;
        step(1);
        sb.start = 1'b0;
        sb.abort = 1'b0;
        step(4);

        // num_tiles=0 behaves as a single tile
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b1, BIG, 0, BIG, nb);
        go(8'd0, 1'b0);
        step(16);
        chk("s6_drained", q.size(), 32'd0);

        // reset mid-COMPUTE clears outputs at once, then block idles
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b1, BIG, 0, t0 + 7, nb);
        go(8'd1, 1'b0);
        step(7);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {17'd0, sb.busy,
            pack(sb.load_weight, sb.enable_mult, sb.tile_idx, sb.tile_done, sb.done)}, 32'd0);
        step(2);
        reset = 1'b1;
        step(4);
        t0 = cyc;
        push_tile(t0, 8'd0, 1'b1, 1'b1, BIG, 0, BIG, nb);
        go(8'd1, 1'b0);
        step(16);
        chk("final_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
